// File: rtl/max7219_serial_driver.sv
// MAX7219 3-wire serial driver: snapshots eight digit patterns plus intensity on a strobe and shifts them out as 16-bit register writes.
// Latency: first DIN bit one cycle after the strobe. Each word takes 34*CLK_DIV cycles. A frame is 13 words after reset and 9 words after that.
// Backpressure: none. A strobe while busy is held as a single pending request, and that request starts the next frame straight from the last GAP.
module max7219_serial_driver #(
    parameter int CLK_DIV = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic [63:0] i_digits,
    input  logic [3:0]  i_intensity,
    output logic        o_busy,
    output logic        o_serial_dout,
    output logic        o_serial_clk,
    output logic        o_serial_load
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        LATCH,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LAST     = 8'(CLK_DIV - 1);
    localparam logic [3:0] IDX_INIT_END = 4'd3;   // the last configuration word (0x0B07)
    localparam logic [3:0] IDX_FRAME    = 4'd4;   // the intensity word, where every refresh frame starts
    localparam logic [3:0] IDX_LAST     = 4'd12;  // the digit 7 word

    // Word table. Indices 0..3 hold the configuration words, index 4 is intensity and indices 5..12 are digits 0..7.
    function automatic logic [15:0] word_sel(input logic [3:0]  idx,
                                             input logic [63:0] dig,
                                             input logic [3:0]  inten);
        logic [2:0] slot;
        slot = 3'(idx - 4'd5);
        case (idx)
            4'd0:    word_sel = 16'h0F00;
            4'd1:    word_sel = 16'h0C01;
            4'd2:    word_sel = 16'h0900;
            4'd3:    word_sel = 16'h0B07;
            4'd4:    word_sel = {12'h0A0, inten};
            default: word_sel = {4'h0, 4'(idx - 4'd4), dig[{slot, 3'b000} +: 8]};
        endcase
    endfunction

    state_t      state;
    logic [7:0]  cnt;
    logic [3:0]  bit_idx;
    logic [3:0]  word_idx;
    logic [15:0] word_q;
    logic [63:0] snap_digits;
    logic [3:0]  snap_int;
    logic        init_pending;
    logic        stb_pending;

    logic        phase_end;
    logic        req;
    logic        start_now;
    logic        advance;
    logic [3:0]  start_idx;
    logic [15:0] start_word;
    logic [3:0]  next_idx;
    logic [15:0] next_word;

    // Phase timing, and the choice of the first word of a new frame or the next word of the current frame.
    always_comb begin
        phase_end  = (cnt == DIV_LAST);
        req        = i_stb || stb_pending;
        start_now  = ((state == IDLE) && req) ||
                     ((state == GAP) && phase_end && (word_idx == IDX_LAST) && req);
        advance    = (state == GAP) && phase_end && (word_idx != IDX_LAST);
        start_idx  = init_pending ? 4'd0 : IDX_FRAME;
        start_word = word_sel(start_idx, i_digits, i_intensity);
        next_idx   = word_idx + 4'd1;
        next_word  = word_sel(next_idx, snap_digits, snap_int);
    end

    // Main sequencer. The FETCH cycle counts as the first clk-low cycle of bit 15, so a word is exactly 34*CLK_DIV cycles long.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            bit_idx       <= 4'd0;
            word_idx      <= 4'd0;
            word_q        <= 16'd0;
            snap_digits   <= 64'd0;
            snap_int      <= 4'd0;
            init_pending  <= 1'b1;
            stb_pending   <= 1'b0;
            o_busy        <= 1'b0;
            o_serial_dout <= 1'b0;
            o_serial_clk  <= 1'b0;
            o_serial_load <= 1'b0;
        end else begin
            if (i_stb && (state != IDLE)) begin
                stb_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    o_busy <= 1'b0;
                end

                FETCH, SHIFT: begin
                    state <= SHIFT;
                    if (!phase_end) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        cnt <= 8'd0;
                        if (!o_serial_clk) begin
                            o_serial_clk <= 1'b1;
                        end else begin
                            o_serial_clk <= 1'b0;
                            if (bit_idx == 4'd0) begin
                                state         <= LATCH;
                                o_serial_dout <= 1'b0;
                                o_serial_load <= 1'b1;
                            end else begin
                                bit_idx       <= bit_idx - 4'd1;
                                o_serial_dout <= word_q[4'(bit_idx - 4'd1)];
                            end
                        end
                    end
                end

                LATCH: begin
                    if (!phase_end) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        cnt           <= 8'd0;
                        o_serial_load <= 1'b0;
                        state         <= GAP;
                        if (init_pending && (word_idx == IDX_INIT_END)) begin
                            init_pending <= 1'b0;
                        end
                    end
                end

                GAP: begin
                    if (!phase_end) begin
                        cnt <= cnt + 8'd1;
                    end else if (advance) begin
                        cnt           <= 8'd0;
                        word_idx      <= next_idx;
                        word_q        <= next_word;
                        bit_idx       <= 4'd15;
                        o_serial_dout <= next_word[15];
                        state         <= FETCH;
                    end else begin
                        cnt    <= 8'd0;
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Frame start from IDLE or from the end of the last GAP. This takes a fresh snapshot and overrides the IDLE entry above.
            if (start_now) begin
                snap_digits   <= i_digits;
                snap_int      <= i_intensity;
                stb_pending   <= 1'b0;
                word_idx      <= start_idx;
                word_q        <= start_word;
                bit_idx       <= 4'd15;
                cnt           <= 8'd0;
                o_serial_dout <= start_word[15];
                o_serial_clk  <= 1'b0;
                o_serial_load <= 1'b0;
                o_busy        <= 1'b1;
                state         <= FETCH;
            end
        end
    end

endmodule
